// File: rtl/jpeg_rle_reader.sv
// jpeg_rle_reader: walks one quantized 8x8 block from the output memory in
// zigzag order and turns it into JPEG run-length tokens (DC diff, AC, ZRL, EOB).
module jpeg_rle_reader #(
    parameter int AW = 5,
    parameter int CW = 12
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          dc_clr_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic [31:0]   mem_dat_i,
    output logic          tok_valid_o,
    input  logic          tok_ready_i,
    output logic          tok_dc_o,
    output logic          tok_eob_o,
    output logic [3:0]    tok_run_o,
    output logic [3:0]    tok_size_o,
    output logic [CW-1:0] tok_amp_o
);

    localparam int MAXV = (1 << (CW - 1)) - 1;

    // zigzag index -> raster index
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic [3:0] {
        S_IDLE, S_RD, S_LAT, S_EVAL, S_ZRL, S_EMIT, S_NEXT, S_EOB, S_DONE
    } state_t;

    typedef struct packed {
        logic          dc;
        logic          eob;
        logic [3:0]    run;
        logic [3:0]    size;
        logic [CW-1:0] amp;
    } tok_t;

    function automatic logic signed [CW-1:0] sat(input int v);
        if (v > MAXV)       return CW'(MAXV);
        else if (v < -MAXV) return CW'(-MAXV);
        else                return CW'(v);
    endfunction

    function automatic logic [3:0] size_of(input logic [CW-1:0] mag);
        logic [3:0] s;
        s = '0;
        for (int b = 0; b < CW; b++) if (mag[b]) s = 4'(b + 1);
        return s;
    endfunction

    // negative values send the ones-complement of |v| trimmed to size bits
    function automatic logic [CW-1:0] amp_of(input logic neg, input logic [CW-1:0] mag,
                                             input logic [3:0] sz);
        logic [CW-1:0] m;
        m = '0;
        for (int b = 0; b < CW; b++) if (b < int'(sz)) m[b] = 1'b1;
        return neg ? (~mag & m) : mag;
    endfunction

    function automatic tok_t mk_tok(input logic dc, input logic eob, input logic [3:0] run,
                                    input logic [3:0] size, input logic [CW-1:0] amp);
        tok_t t;
        t.dc = dc; t.eob = eob; t.run = run; t.size = size; t.amp = amp;
        return t;
    endfunction

    state_t               state_q, state_d;
    logic [5:0]           idx_q, idx_d;
    logic [5:0]           run_q, run_d;
    logic signed [CW-1:0] pred_q, pred_d;
    logic signed [CW-1:0] coef_q, coef_d;
    logic [3:0]           psize_q, psize_d;
    logic [CW-1:0]        pamp_q, pamp_d;
    tok_t                 tok_q, tok_d;

    logic [5:0]           raster;
    logic signed [15:0]   half_w;
    logic signed [CW-1:0] coef_sat, diff_sat;
    logic [CW-1:0]        ac_mag, dc_mag;
    logic [3:0]           ac_size, dc_size;
    logic [CW-1:0]        ac_amp, dc_amp;
    logic [5:0]           run_m16;

    assign raster   = ZZ[idx_q];
    assign half_w   = raster[0] ? mem_dat_i[15:0] : mem_dat_i[31:16];
    assign coef_sat = sat(int'(half_w));
    assign diff_sat = sat(int'(coef_sat) - int'(pred_q));
    assign ac_mag   = coef_sat[CW-1] ? -coef_sat : coef_sat;
    assign dc_mag   = diff_sat[CW-1] ? -diff_sat : diff_sat;
    assign ac_size  = size_of(ac_mag);
    assign dc_size  = size_of(dc_mag);
    assign ac_amp   = amp_of(coef_sat[CW-1], ac_mag, ac_size);
    assign dc_amp   = amp_of(diff_sat[CW-1], dc_mag, dc_size);
    assign run_m16  = run_q - 6'd16;

    assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o      = (state_q == S_DONE);
    assign mem_addr_o  = busy_o ? AW'(raster[5:1]) : '0;
    assign tok_valid_o = (state_q == S_EMIT) || (state_q == S_ZRL) || (state_q == S_EOB);
    assign tok_dc_o    = tok_q.dc;
    assign tok_eob_o   = tok_q.eob;
    assign tok_run_o   = tok_q.run;
    assign tok_size_o  = tok_q.size;
    assign tok_amp_o   = tok_q.amp;

    // next-state, token build and run/predictor bookkeeping
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        run_d   = run_q;
        pred_d  = pred_q;
        coef_d  = coef_q;
        psize_d = psize_q;
        pamp_d  = pamp_q;
        tok_d   = tok_q;
        case (state_q)
            S_IDLE: begin
                if (dc_clr_i) pred_d = '0;
                if (start_i) begin
                    state_d = S_RD;
                    idx_d   = '0;
                    run_d   = '0;
                end
            end
            S_RD:  state_d = S_LAT;
            S_LAT: state_d = S_EVAL;
            S_EVAL: begin
                coef_d = coef_sat;
                if (idx_q == 6'd0) begin
                    tok_d   = mk_tok(1'b1, 1'b0, 4'd0, dc_size, dc_amp);
                    state_d = S_EMIT;
                end else if (coef_sat == '0) begin
                    if (idx_q == 6'd63) begin
                        // trailing zeros collapse into EOB, pending run dropped
                        tok_d   = mk_tok(1'b0, 1'b1, 4'd0, 4'd0, '0);
                        run_d   = '0;
                        state_d = S_EOB;
                    end else begin
                        run_d   = run_q + 6'd1;
                        state_d = S_NEXT;
                    end
                end else begin
                    psize_d = ac_size;
                    pamp_d  = ac_amp;
                    if (run_q >= 6'd16) begin
                        tok_d   = mk_tok(1'b0, 1'b0, 4'd15, 4'd0, '0);
                        state_d = S_ZRL;
                    end else begin
                        tok_d   = mk_tok(1'b0, 1'b0, run_q[3:0], ac_size, ac_amp);
                        run_d   = '0;
                        state_d = S_EMIT;
                    end
                end
            end
            S_ZRL: begin
                if (tok_ready_i) begin
                    if (run_m16 >= 6'd16) begin
                        run_d = run_m16;
                    end else begin
                        tok_d   = mk_tok(1'b0, 1'b0, run_m16[3:0], psize_q, pamp_q);
                        run_d   = '0;
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (tok_ready_i) begin
                    if (tok_q.dc) pred_d = coef_q;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == 6'd63) state_d = S_DONE;
                else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = S_RD;
                end
            end
            S_EOB: if (tok_ready_i) state_d = S_DONE;
            S_DONE: begin
                tok_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            run_q   <= '0;
            pred_q  <= '0;
            coef_q  <= '0;
            psize_q <= '0;
            pamp_q  <= '0;
            tok_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
            pred_q  <= pred_d;
            coef_q  <= coef_d;
            psize_q <= psize_d;
            pamp_q  <= pamp_d;
            tok_q   <= tok_d;
        end
    end

endmodule

// File: tb/tb_jpeg_rle_reader.sv
// Directed bench for jpeg_rle_reader: memory model, token capture, fixed vectors.
module tb_jpeg_rle_reader;
    localparam int AW = 5;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          dc_clr = 1'b0;
    logic          tok_ready = 1'b1;
    logic          busy, done, tok_valid, tok_dc, tok_eob;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_dat;
    logic [3:0]    tok_run, tok_size;
    logic [CW-1:0] tok_amp;

    logic [31:0]   mem [32];
    int            n_tests = 0;
    int            n_fail = 0;
    int            done_cnt = 0;
    logic [21:0]   got [$];
    logic [21:0]   exq [$];

    jpeg_rle_reader #(.AW(AW), .CW(CW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .dc_clr_i(dc_clr),
        .busy_o(busy), .done_o(done), .mem_addr_o(mem_addr), .mem_dat_i(mem_dat),
        .tok_valid_o(tok_valid), .tok_ready_i(tok_ready), .tok_dc_o(tok_dc),
        .tok_eob_o(tok_eob), .tok_run_o(tok_run), .tok_size_o(tok_size), .tok_amp_o(tok_amp)
    );

    always #5 clk = ~clk;

    // synchronous read memory, data one cycle after address
    always @(posedge clk) mem_dat <= mem[mem_addr];

    // capture accepted tokens and done pulses
    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (!rst && tok_valid && tok_ready)
            got.push_back({tok_dc, tok_eob, tok_run, tok_size, tok_amp});
    end

    function automatic logic [21:0] tk(input logic dc, input logic eob, input int run,
                                       input int size, input int amp);
        return {dc, eob, 4'(run), 4'(size), 12'(amp)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mem();
        for (int k = 0; k < 32; k++) mem[k] = 32'h0;
    endtask

    task automatic kick(input logic clr);
        @(negedge clk);
        start = 1'b1; dc_clr = clr;
        @(negedge clk);
        start = 1'b0; dc_clr = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int c;
        c = 0;
        while (done_cnt == d0 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic cmp_toks(input string tag, input int base);
        chk({tag, "_ntok"}, 32'(got.size() - base), 32'(exq.size()));
        for (int k = 0; k < exq.size(); k++)
            if (base + k < got.size()) chk({tag, "_tok"}, {10'd0, got[base + k]}, {10'd0, exq[k]});
        exq.delete();
    endtask

    task automatic blk(input string tag, input logic clr);
        int d0, base;
        d0 = done_cnt; base = got.size();
        kick(clr);
        wait_done(tag, d0);
        cmp_toks(tag, base);
    endtask

    initial begin
        int d0, base, c;
        logic [21:0] zrl;
        zrl = tk(0, 0, 15, 0, 0);
        clr_mem();
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_valid", {31'd0, tok_valid}, 32'd0);
        chk("rst_addr", {27'd0, mem_addr}, 32'd0);
        rst = 1'b0;

        // all-zero block
        exq.push_back(tk(1, 0, 0, 0, 0)); exq.push_back(tk(0, 1, 0, 0, 0));
        blk("zero", 1'b1);

        // DC predictor across two blocks: 5, then 3 (diff -2)
        mem[0] = {16'd5, 16'd0};
        exq.push_back(tk(1, 0, 0, 3, 5)); exq.push_back(tk(0, 1, 0, 0, 0));
        blk("dcA", 1'b0);
        mem[0] = {16'd3, 16'd0};
        exq.push_back(tk(1, 0, 0, 2, 1)); exq.push_back(tk(0, 1, 0, 0, 0));
        blk("dcB", 1'b0);

        // raster 8 = 3, raster 63 = -1, with back-pressure on the first ZRL
        clr_mem();
        mem[4]  = {16'd3, 16'd0};
        mem[31] = {16'd0, 16'hFFFF};
        exq.push_back(tk(1, 0, 0, 0, 0)); exq.push_back(tk(0, 0, 1, 2, 3));
        exq.push_back(zrl); exq.push_back(zrl); exq.push_back(zrl);
        exq.push_back(tk(0, 0, 12, 1, 0));
        d0 = done_cnt; base = got.size();
        kick(1'b1);
        c = 0;
        while (got.size() - base < 2 && c < 500) begin @(negedge clk); c++; end
        chk("bp_tok2", {31'd0, (got.size() - base) >= 2}, 32'd1);
        tok_ready = 1'b0;
        c = 0;
        while (!tok_valid && c < 500) begin @(negedge clk); c++; end
        chk("bp_valid", {31'd0, tok_valid}, 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", {9'd0, tok_valid, tok_dc, tok_eob, tok_run, tok_size, tok_amp},
                {9'd0, 1'b1, zrl});
        end
        tok_ready = 1'b1;
        wait_done("bp", d0);
        cmp_toks("bp", base);

        // only zigzag 40 (raster 29) = 1
        clr_mem();
        mem[14] = {16'd0, 16'd1};
        exq.push_back(tk(1, 0, 0, 0, 0)); exq.push_back(zrl); exq.push_back(zrl);
        exq.push_back(tk(0, 0, 7, 1, 1)); exq.push_back(tk(0, 1, 0, 0, 0));
        blk("zz40", 1'b1);

        // saturation, plus a start pulse while busy that must be ignored
        clr_mem();
        mem[0] = {16'h8000, 16'h7FFF};
        exq.push_back(tk(1, 0, 0, 11, 0)); exq.push_back(tk(0, 0, 0, 11, 12'h7FF));
        exq.push_back(tk(0, 1, 0, 0, 0));
        d0 = done_cnt; base = got.size();
        kick(1'b1);
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("sat", d0);
        cmp_toks("sat", base);
        repeat (20) @(negedge clk);
        chk("ign_busy", {31'd0, busy}, 32'd0);
        chk("ign_done", 32'(done_cnt - d0), 32'd1);

        // predictor holds -2047; dc_clr mid-block must be ignored
        exq.push_back(tk(1, 0, 0, 0, 0)); exq.push_back(tk(0, 0, 0, 11, 12'h7FF));
        exq.push_back(tk(0, 1, 0, 0, 0));
        d0 = done_cnt; base = got.size();
        kick(1'b0);
        repeat (20) @(negedge clk);
        dc_clr = 1'b1;
        @(negedge clk);
        dc_clr = 1'b0;
        wait_done("pred", d0);
        cmp_toks("pred", base);
        exq.push_back(tk(1, 0, 0, 0, 0)); exq.push_back(tk(0, 0, 0, 11, 12'h7FF));
        exq.push_back(tk(0, 1, 0, 0, 0));
        blk("clrign", 1'b0);

        // reset while a ZRL is being presented
        clr_mem();
        mem[14] = {16'd0, 16'd1};
        d0 = done_cnt;
        kick(1'b1);
        c = 0;
        while (!(tok_valid && tok_run == 4'd15) && c < 500) begin @(negedge clk); c++; end
        chk("zrl_seen", {31'd0, tok_valid && tok_run == 4'd15}, 32'd1);
        tok_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_outs", {9'd0, busy, done, tok_valid, tok_dc, tok_eob, tok_run, tok_size,
                         mem_addr, 1'b0} | {20'd0, tok_amp}, 32'd0);
        rst = 1'b0;
        tok_ready = 1'b1;
        repeat (300) @(negedge clk);
        chk("rst_nodone", 32'(done_cnt - d0), 32'd0);
        chk("rst_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/jpeg_rle_reader.md
Name: jpeg_rle_reader

Overview:
- Drains one quantized 8x8 block from the JPEG accelerator output memory. That memory holds 32 words, written by the DCT/quantizer path.
- Reads the coefficients back in zigzag order.
- Produces JPEG run-length tokens for the downstream Huffman packer: DC difference, AC (run,size,amplitude), ZRL and EOB.
- It is the reader at the far end of the quantizer-to-output-memory path. It runs in place of software walking the coefficients over Wishbone.

Parameters:
- AW, 5, output-memory word address width (32 words per block).
- CW, 12, amplitude field width. Coefficients saturate to ±(2^(CW-1)-1).

Ports:
- clk_i  in  1  system clock (wb.clk)
- rst_i  in  1  synchronous active-high reset (wb.rst)
- start_i  in  1  one-cycle pulse: block complete in output memory
- dc_clr_i  in  1  clear DC predictor to 0 (start of scan)
- busy_o  out  1  high from accepted start_i until done_o
- done_o  out  1  one-cycle pulse after the last token is accepted
- mem_addr_o  out  AW  output-memory read address
- mem_dat_i  in  32  read data, valid exactly 1 cycle after mem_addr_o
- tok_valid_o  out  1  token valid
- tok_ready_i  in  1  consumer accepts token when valid&&ready
- tok_dc_o  out  1  token is the DC difference
- tok_eob_o  out  1  token is EOB (run=0,size=0)
- tok_run_o  out  4  zero run preceding the coefficient
- tok_size_o  out  4  magnitude category 0..11
- tok_amp_o  out  CW  amplitude bits, right-aligned, upper bits zero

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset state: outputs 0, FSM in IDLE, predictor 0, run counter 0. Reset mid-block aborts with no done_o.
- Memory packing: word k holds raster coefficient 2k in [31:16] and 2k+1 in [15:0], 16-bit two's complement.
- Saturation: each coefficient saturates to [-2047,2047] before use. The DC difference (coef − pred) also saturates to [-2047,2047].
- Zigzag lookup: an internal 64-entry table zz[i] maps zigzag index i to raster index r. For each i, mem_addr_o=r>>1; half select = r[0] (0 selects [31:16]).
- FSM states and transitions:
  - IDLE: start_i → RD, i=0, run=0, busy_o=1.
  - RD: drive address → LAT.
  - LAT: wait one cycle for read latency → EVAL.
  - EVAL: classify coefficient i; go to EMIT, ZRL, EOB or NEXT.
  - ZRL: emit (15,0), run−=16; repeat while run≥16, then EMIT.
  - EMIT: present token; on handshake → NEXT.
  - NEXT: i==63 → DONE, else i++ → RD.
  - EOB: emit EOB; on handshake → DONE.
  - DONE: pulse done_o, clear busy_o → IDLE.
- i=0 (DC): always emits one token, tok_dc_o=1, run=0, size/amp of diff. Predictor ← saturated coef on handshake. A zero diff gives size 0, amp 0.
- AC, coef==0, i<63: run++, no token.
- AC, coef!=0: if run≥16, go through ZRL first. Then emit (run,size,amp) and set run=0.
- i==63, coef==0: emit EOB. Pending run and any ZRLs are discarded (ZRL never precedes EOB).
- i==63, coef!=0: emit normal token, no EOB.
- Size rule: size = bit length of |v| (0 for v=0).
- Amplitude rule: v>0 → amp=v; v<0 → amp = (v−1) masked to size bits (ones-complement of |v|).
- Handshake: while tok_valid_o && !tok_ready_i, all tok_* outputs hold stable. tok_valid_o drops the cycle after acceptance unless the next token is ready.
- start_i while busy_o: ignored.
- dc_clr_i: applies when busy_o=0. If it arrives with start_i, the clear takes effect before that block's DC difference. While busy it is ignored.
- Throughput: minimum 4 cycles per zigzag index with no back-pressure.

Test Plan:
- All-zero block, pred 0 → DC(dc=1,size 0,amp 0), EOB, done_o; exactly 2 tokens.
- Block A DC=5, rest 0, then block B DC=3 → A: DC size 3 amp 101. B: diff −2 → DC size 2 amp 01. Each block ends in EOB.
- Raster 8 (zigzag 2)=3, raster 63=−1, rest 0 → DC, (1,2,11), ZRL, ZRL, ZRL, (12,1,0); no EOB.
- Only zigzag 40 =1, raster 0=0 → DC(size 0), ZRL, ZRL, (7,1,1), EOB.
- Raster 1 = 0x7FFF and −32768 in DC with pred 0 → saturation to 2047/−2047, size 11, amp 0x7FF / 0x000.
- Other checks:
  - tok_ready_i low 5 cycles mid-block → tokens stable and none lost.
  - rst_i during ZRL → all outputs 0 next cycle, no done_o.
  - start_i while busy → ignored.
